// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake and status bundle for the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned data_bits  = 8,
  parameter int unsigned fifo_depth = 4
);
  localparam int unsigned count_w = $clog2(fifo_depth) + 1;

  logic [data_bits-1:0] i_data;
  logic                 i_req;
  logic                 o_cts;
  logic                 o_serial;
  logic                 o_idle;
  logic [count_w-1:0]   o_count;

  modport master (
    output i_data, i_req,
    input  o_cts, o_serial, o_idle, o_count
  );

  modport slave (
    input  i_data, i_req,
    output o_cts, o_serial, o_idle, o_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART serializer: byte FIFO feeding a start/data/parity/stop frame FSM.
// Frames are sent back to back while the FIFO holds data; the line idles high.
module uart_tx_fifo #(
  parameter int unsigned cycles_per_bit = 3,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity_mode    = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic         clock,
  input  logic         i_rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned addr_w  = $clog2(fifo_depth);
  localparam int unsigned count_w = addr_w + 1;
  localparam int unsigned timer_w = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  localparam int unsigned index_w = $clog2(data_bits);
  localparam bit          has_parity = (parity_mode != 0);
  localparam bit          odd_parity = (parity_mode == 2);

  generate
    if (cycles_per_bit < 1 || data_bits < 5 || data_bits > 9 || parity_mode > 2 ||
        (stop_bits != 1 && stop_bits != 2) || fifo_depth < 2 ||
        (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameter values");
    end
  endgenerate

  typedef enum logic [2:0] {
    st_idle,
    st_start,
    st_data,
    st_parity,
    st_stop
  } state_t;

  logic [data_bits-1:0] mem [fifo_depth];
  logic [addr_w-1:0]    wr_ptr;
  logic [addr_w-1:0]    rd_ptr;
  logic [count_w-1:0]   count_q;
  logic                 full;
  logic                 push;
  logic                 pop;

  state_t               state_q, state_d;
  logic [timer_w-1:0]   timer_q, timer_d;
  logic [index_w-1:0]   index_q, index_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 last_tick;

  // Acceptance depends on registered occupancy only, so a full FIFO refuses even on a pop edge.
  assign full         = (count_q == count_w'(fifo_depth));
  assign push         = bus.i_req && !full;
  assign bus.o_cts    = !full;
  assign bus.o_count  = count_q;
  assign bus.o_serial = serial_q;
  assign bus.o_idle   = (state_q == st_idle) && (count_q == '0);
  assign last_tick    = (timer_q == timer_w'(cycles_per_bit - 1));

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + addr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_w'(1);
      end
      count_q <= count_q + count_w'(push) - count_w'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state_q  <= st_idle;
      timer_q  <= '0;
      index_q  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    index_d  = index_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    serial_d = 1'b1;

    case (state_q)
      st_idle: begin
        pop = (count_q != '0);
      end
      st_start: begin
        if (last_tick) begin
          state_d = st_data;
          timer_d = '0;
          index_d = '0;
        end else begin
          timer_d = timer_q + timer_w'(1);
        end
      end
      st_data: begin
        if (last_tick) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (index_q == index_w'(data_bits - 1)) begin
            index_d = '0;
            state_d = has_parity ? st_parity : st_stop;
          end else begin
            index_d = index_q + index_w'(1);
          end
        end else begin
          timer_d = timer_q + timer_w'(1);
        end
      end
      st_parity: begin
        if (last_tick) begin
          timer_d = '0;
          index_d = '0;
          state_d = st_stop;
        end else begin
          timer_d = timer_q + timer_w'(1);
        end
      end
      st_stop: begin
        if (last_tick) begin
          timer_d = '0;
          if (index_q == index_w'(stop_bits - 1)) begin
            index_d = '0;
            state_d = st_idle;
            pop     = (count_q != '0);
          end else begin
            index_d = index_q + index_w'(1);
          end
        end else begin
          timer_d = timer_q + timer_w'(1);
        end
      end
      default: begin
        state_d = st_idle;
        timer_d = '0;
        index_d = '0;
      end
    endcase

    // A pop from IDLE or the final stop cycle starts the next frame with no gap.
    if (pop) begin
      shift_d = mem[rd_ptr];
      par_d   = (^mem[rd_ptr]) ^ odd_parity;
      state_d = st_start;
      timer_d = '0;
      index_d = '0;
    end

    // The line register takes the value of the bit the FSM is about to present.
    case (state_d)
      st_start:  serial_d = 1'b0;
      st_data:   serial_d = shift_d[0];
      st_parity: serial_d = par_d;
      default:   serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four parameter sets share one clock and reset;
// the serial line of the instance under test is selected through a monitor mux.
module tb_uart_tx_fifo;

  logic clock = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  logic mon_serial;
  logic mon_idle;

  always #5 clock = ~clock;

  uart_tx_fifo_if #(.data_bits(8), .fifo_depth(4)) if0 ();
  uart_tx_fifo_if #(.data_bits(8), .fifo_depth(4)) if1 ();
  uart_tx_fifo_if #(.data_bits(8), .fifo_depth(4)) if2 ();
  uart_tx_fifo_if #(.data_bits(7), .fifo_depth(4)) if3 ();

  uart_tx_fifo #(.cycles_per_bit(3), .data_bits(8), .parity_mode(0), .stop_bits(1), .fifo_depth(4))
    u0 (.clock(clock), .i_rst(rst), .bus(if0));
  uart_tx_fifo #(.cycles_per_bit(3), .data_bits(8), .parity_mode(1), .stop_bits(1), .fifo_depth(4))
    u1 (.clock(clock), .i_rst(rst), .bus(if1));
  uart_tx_fifo #(.cycles_per_bit(3), .data_bits(8), .parity_mode(2), .stop_bits(1), .fifo_depth(4))
    u2 (.clock(clock), .i_rst(rst), .bus(if2));
  uart_tx_fifo #(.cycles_per_bit(5), .data_bits(7), .parity_mode(0), .stop_bits(2), .fifo_depth(4))
    u3 (.clock(clock), .i_rst(rst), .bus(if3));

  always_comb begin
    case (sel)
      1:       begin mon_serial = if1.o_serial; mon_idle = if1.o_idle; end
      2:       begin mon_serial = if2.o_serial; mon_idle = if2.o_idle; end
      3:       begin mon_serial = if3.o_serial; mon_idle = if3.o_idle; end
      default: begin mon_serial = if0.o_serial; mon_idle = if0.o_idle; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame, bit 0 = start bit; returns the frame length in bits.
  function automatic int frame_vec(input logic [8:0] d, input int nb, input int pm,
                                   input int ns, output logic [15:0] vec);
    logic p;
    int   len;
    vec    = '1;
    vec[0] = 1'b0;
    p      = 1'b0;
    for (int i = 0; i < nb; i++) begin
      vec[1+i] = d[i];
      p        = p ^ d[i];
    end
    len = 1 + nb;
    if (pm != 0) begin
      vec[len] = (pm == 1) ? p : ~p;
      len++;
    end
    return len + ns;
  endfunction

  // Called at the negedge of the first start-bit cycle; returns at the negedge after the frame.
  task automatic expect_frame(input string tag, input logic [8:0] d, input int nb, input int pm,
                              input int ns, input int cpb);
    logic [15:0] vec;
    int          len;
    len = frame_vec(d, nb, pm, ns, vec);
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(mon_serial), 32'(vec[b]));
        if (b == len - 1 && c == cpb - 1) chk({tag, "_idle_last"}, 32'(mon_idle), 32'd0);
        @(negedge clock);
      end
    end
  endtask

  task automatic push0(input logic [7:0] d);
    if0.i_req  = 1'b1;
    if0.i_data = d;
    @(posedge clock);
    @(negedge clock);
    if0.i_req  = 1'b0;
  endtask

  logic        rec_s   [200];
  logic [2:0]  rec_c   [200];
  logic        rec_cts [200];
  logic [15:0] fv;
  logic [7:0]  burst_exp;
  int          k;
  int          flen;
  int          t0;

  initial begin
    rst = 1'b1;
    if0.i_req = 1'b1; if0.i_data = 8'hFF;
    if1.i_req = 1'b1; if1.i_data = 8'hFF;
    if2.i_req = 1'b1; if2.i_data = 8'hFF;
    if3.i_req = 1'b1; if3.i_data = 7'h7F;

    // Reset held for two edges with requests active
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_serial", 32'(if0.o_serial), 32'd1);
    chk("rst_cts",    32'(if0.o_cts),    32'd1);
    chk("rst_idle",   32'(if0.o_idle),   32'd1);
    chk("rst_count",  32'(if0.o_count),  32'd0);
    chk("rst_count3", 32'(if3.o_count),  32'd0);
    rst = 1'b0;
    if0.i_req = 1'b0; if1.i_req = 1'b0; if2.i_req = 1'b0; if3.i_req = 1'b0;
    @(negedge clock);
    chk("rst_nothing_queued", 32'(if0.o_count), 32'd0);
    chk("rst_still_idle",     32'(if0.o_idle),  32'd1);

    // Default frame of 0x48
    sel = 0;
    push0(8'h48);
    chk("d48_cycleN_serial", 32'(if0.o_serial), 32'd1);
    chk("d48_cycleN_count",  32'(if0.o_count),  32'd1);
    @(negedge clock);
    chk("d48_popped_count", 32'(if0.o_count), 32'd0);
    chk("d48_busy_idle",    32'(if0.o_idle),  32'd0);
    expect_frame("d48", 9'h048, 8, 0, 1, 3);
    chk("d48_idle_after30", 32'(if0.o_idle),   32'd1);
    chk("d48_line_high",    32'(if0.o_serial), 32'd1);

    // Even parity, 0x07
    sel = 1;
    if1.i_req = 1'b1; if1.i_data = 8'h07;
    @(posedge clock);
    @(negedge clock);
    if1.i_req = 1'b0;
    @(negedge clock);
    expect_frame("pe07", 9'h007, 8, 1, 1, 3);
    chk("pe07_idle_after33", 32'(if1.o_idle), 32'd1);

    // Odd parity, 0x07
    sel = 2;
    if2.i_req = 1'b1; if2.i_data = 8'h07;
    @(posedge clock);
    @(negedge clock);
    if2.i_req = 1'b0;
    @(negedge clock);
    expect_frame("po07", 9'h007, 8, 2, 1, 3);
    chk("po07_idle_after33", 32'(if2.o_idle), 32'd1);

    // 7 data bits, 2 stop bits, 5 cycles per bit
    sel = 3;
    if3.i_req = 1'b1; if3.i_data = 7'h55;
    @(posedge clock);
    @(negedge clock);
    if3.i_req = 1'b0;
    @(negedge clock);
    expect_frame("w7s2", 9'h055, 7, 0, 2, 5);
    chk("w7s2_idle_after50", 32'(if3.o_idle), 32'd1);

    // Burst of six words into a depth-4 FIFO; refused words are retried
    sel = 0;
    k = 0;
    for (int t = 0; t < 200; t++) begin
      if0.i_req  = (k < 6);
      if0.i_data = 8'(k + 1);
      rec_cts[t] = if0.o_cts;
      @(posedge clock);
      if (if0.i_req && rec_cts[t]) k++;
      @(negedge clock);
      rec_s[t] = if0.o_serial;
      rec_c[t] = if0.o_count;
    end
    if0.i_req = 1'b0;
    chk("burst_all_sent", 32'(k), 32'd6);
    chk("burst_cnt_t1",   32'(rec_c[1]),   32'd1);
    chk("burst_cnt_t2",   32'(rec_c[2]),   32'd2);
    chk("burst_cnt_t4",   32'(rec_c[4]),   32'd4);
    chk("burst_cts_t5",   32'(rec_cts[5]), 32'd0);
    chk("burst_cnt_t30",  32'(rec_c[30]),  32'd4);
    chk("burst_cnt_t31",  32'(rec_c[31]),  32'd3);
    chk("burst_cts_t32",  32'(rec_cts[32]),32'd1);
    chk("burst_cnt_t32",  32'(rec_c[32]),  32'd4);
    chk("burst_cnt_t61",  32'(rec_c[61]),  32'd3);
    chk("burst_cnt_t151", 32'(rec_c[151]), 32'd0);
    for (int t = 0; t < 200; t++) begin
      if (rec_c[t] > 3'd4) chk($sformatf("burst_cnt_max_t%0d", t), 32'(rec_c[t]), 32'd4);
    end
    chk("burst_line_t0", 32'(rec_s[0]), 32'd1);
    for (int w = 0; w < 6; w++) begin
      burst_exp = 8'(w + 1);
      flen = frame_vec({1'b0, burst_exp}, 8, 0, 1, fv);
      for (int b = 0; b < flen; b++) begin
        for (int c = 0; c < 3; c++) begin
          t0 = 1 + w * 30 + b * 3 + c;
          chk($sformatf("burst_w%0d_b%0d_c%0d", w, b, c), 32'(rec_s[t0]), 32'(fv[b]));
        end
      end
    end
    for (int t = 181; t < 200; t++) begin
      chk($sformatf("burst_tail_t%0d", t), 32'(rec_s[t]), 32'd1);
    end
    chk("burst_idle_end", 32'(if0.o_idle), 32'd1);

    // Mid-frame reset during data bit 3 of 0x00 with two words queued
    if0.i_req = 1'b1;
    if0.i_data = 8'h00;
    @(posedge clock);
    @(negedge clock);
    if0.i_data = 8'h11;
    @(posedge clock);
    @(negedge clock);
    if0.i_data = 8'h22;
    @(posedge clock);
    @(negedge clock);
    if0.i_req = 1'b0;
    chk("mid_queued", 32'(if0.o_count), 32'd2);
    repeat (11) @(negedge clock);
    chk("mid_bit3_low", 32'(if0.o_serial), 32'd0);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("mid_rst_serial", 32'(if0.o_serial), 32'd1);
    chk("mid_rst_count",  32'(if0.o_count),  32'd0);
    chk("mid_rst_idle",   32'(if0.o_idle),   32'd1);
    chk("mid_rst_cts",    32'(if0.o_cts),    32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("mid_quiet_%0d", i), 32'(if0.o_serial), 32'd1);
    end
    push0(8'hA5);
    @(negedge clock);
    expect_frame("mid_a5", 9'h0A5, 8, 0, 1, 3);
    chk("mid_a5_idle", 32'(if0.o_idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered, parametrised UART serializer; next generation of the plain transmitter used in the uart hello/loopback top.
- Adds a byte FIFO so producers can burst without waiting on the bit timer.
- Adds configurable data width, optional even/odd parity and 1 or 2 stop bits.
- Drops into the top in place of the existing tx; its serial output feeds rx directly.

Parameters:
- cycles_per_bit, 3, clock cycles per serial bit; must be >= 1.
- data_bits, 8, payload bits per frame; range 5..9.
- parity_mode, 0, parity setting: 0 = none, 1 = even, 2 = odd.
- stop_bits, 1, stop bits per frame; 1 or 2.
- fifo_depth, 4, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_data  in  data_bits  payload to enqueue.
- i_req  in  1  enqueue request; accepted at posedge when o_cts=1.
- o_cts  out  1  clear-to-send; equals 1 exactly when FIFO count != fifo_depth.
- o_serial  out  1  serial line; idles high.
- o_idle  out  1  1 when the FIFO is empty and the FSM is in IDLE.
- o_count  out  clog2(fifo_depth)+1  current FIFO occupancy.

Behaviour:
- Reset, sampled at posedge with i_rst=1:
  - FIFO flushed: pointers 0, count 0.
  - FSM forced to IDLE; bit timer and bit index cleared.
  - Outputs from the next cycle: o_serial=1, o_cts=1, o_idle=1, o_count=0.
  - Reset wins over any simultaneous push or pop.
  - Reset mid-frame aborts the frame; the line returns high the cycle after the reset edge, with no glitch low.
- Push:
  - Fires when i_req && o_cts at a posedge.
  - Writes i_data at the write pointer; pointer wraps modulo fifo_depth.
  - o_cts is a function of registered count only. When full, a request is refused even if a pop occurs on the same edge.
- Pop:
  - Fires only when count != 0 before the edge, so a word pushed at edge N can be popped no earlier than edge N+1.
  - Push and pop on the same edge leave count unchanged.
  - Push alone: count +1. Pop alone: count -1.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - Each bit is held for exactly cycles_per_bit cycles, counted by the bit timer.
  - IDLE: o_serial=1. If count != 0: pop into the shift register, compute parity, go to START.
  - START: o_serial=0; go to DATA.
  - DATA: o_serial = shift[0], LSB first, data_bits bits. Then go to PARITY if parity_mode != 0, else STOP.
  - PARITY: o_serial = XOR of payload (even), or its inverse (odd). Then STOP.
  - STOP: o_serial=1 for stop_bits bit-times.
  - At the last cycle of the final stop bit: if count != 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame timing:
  - Frame length = (1 + data_bits + (parity_mode != 0) + stop_bits) * cycles_per_bit cycles.
  - Push at edge N into an empty, idle block: pop and START at edge N+1; o_serial low from cycle N+1.
- Output timing:
  - o_serial is registered.
  - o_idle is combinational from registered state and count. It stays 0 from the pop edge until the end of the last stop bit.
- Illegal parameter values trigger an elaboration error; no runtime checking.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_req=1 -> o_serial=1, o_cts=1, o_idle=1, o_count=0; nothing enqueued.
- Default parameters, push 0x48 once:
  - o_serial low for cycles N+1..N+3.
  - Then bits 0,0,0,1,0,0,1,0, 3 cycles each.
  - Then high 3 cycles; o_idle returns to 1 exactly 30 cycles after edge N+1.
- Parity, push 0x07:
  - parity_mode=1 -> parity bit 1, frame 33 cycles.
  - parity_mode=2 -> parity bit 0.
- Burst, fifo_depth=4, i_req held for 6 cycles with data 0x01..0x06:
  - o_cts drops when o_count=4.
  - Refused words are held by the bench and retried.
  - Line carries 0x01..0x06 in order with zero idle cycles between frames; o_count never exceeds 4.
- Width/stop: data_bits=7, stop_bits=2, cycles_per_bit=5, push 0x55 -> frame of 50 cycles, alternating 1,0 data LSB first, 10 stop cycles high.
- Mid-frame reset: i_rst=1 during data bit 3 of frame 1 with 2 words queued:
  - o_serial=1 and o_count=0 the next cycle.
  - A later push of 0xA5 transmits a clean, correct frame.
